serv_rf_ram_dbg: RTL and testbench
==================================

# serv_rf_ram_dbg

Register-file RAM for SERV with an integrated debug access port, sitting directly downstream of the bit-serial RAM interface. It is the `width`-bit-wide storage for GPRs and CSRs. It services the core-side write/read port every cycle. While the core is halted, a debug master can read or write a whole 32-bit register through a word-wide request/ack handshake; the block sequences this over `32/width` RAM beats.

## Interface
Parameters:
- `width`, 8, RAM word width; one of 2, 4, 8, 16, 32.
- `csr_regs`, 4, number of CSR slots after the 32 GPRs.
- `depth`, 32*(32+csr_regs)/width, RAM words.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_waddr`  in  $clog2(depth)  core write address.
- `i_wdata`  in  width  core write data.
- `i_wen`  in  1  core write enable.
- `i_raddr`  in  $clog2(depth)  core read address.
- `o_rdata`  out  width  registered read data.
- `i_halted`  in  1  core is halted; debug accesses are accepted only when high.
- `i_dbg_req`  in  1  debug request, level, held until `o_dbg_ack`.
- `i_dbg_we`  in  1  1 = write, 0 = read; sampled at accept.
- `i_dbg_reg`  in  $clog2(32+csr_regs)  register index; sampled at accept.
- `i_dbg_wdata`  in  32  write word; sampled at accept.
- `o_dbg_ack`  out  1  one-cycle completion pulse.
- `o_dbg_err`  out  1  valid with ack: index out of range.
- `o_dbg_rdata`  out  32  read word; valid from ack and held until the next accept.
- `o_dbg_busy`  out  1  FSM not IDLE.

## Operation
- Reset values: FSM IDLE; `o_rdata`, `o_dbg_rdata` = 0; `o_dbg_ack`, `o_dbg_err`, `o_dbg_busy` = 0; beat counter = 0.
- Reset does not clear RAM contents.
- Core port, FSM in IDLE:
  - If `i_wen`, write `mem[i_waddr] <= i_wdata`.
  - Every cycle, `o_rdata <= mem[i_raddr]`.
  - Read-during-write to the same address returns the old data.
- FSM states: IDLE, XFER, DRAIN, ACK.
- IDLE → accept when `i_dbg_req & i_halted`:
  - Latch we, reg, and wdata into a 32-bit shift register.
  - If reg ≥ 32+csr_regs → ACK with err=1, and no RAM access.
  - Otherwise → XFER with beat counter = 0.
- XFER, one beat per cycle, address = {reg, beat} (or reg when width=32):
  - Write: RAM written with `wdata_sr[width-1:0]`, then shift right by width. Writes to reg 0 are suppressed (x0 is never stored).
  - Read: RAM read address = debug address.
  - After the last beat (beat = 32/width−1): write → ACK; read → DRAIN.
- Read capture: in each cycle after a read beat (XFER beats 2..n and DRAIN), `rdata_sr <= {o_rdata_mem, rdata_sr[31:width]}`.
- DRAIN → ACK. In ACK, `o_dbg_rdata` is loaded from `rdata_sr`, forced to 0 for reg 0.
- ACK → IDLE unconditionally. The master must drop `i_dbg_req` in the ACK cycle; if it is still high in IDLE, a new access is accepted.
- Outside IDLE:
  - Core `i_wen` is ignored and writes are dropped.
  - `o_rdata` carries debug read data; the core must not consume it.
- `i_halted` falling mid-access does not abort; the access completes.
- `i_rst` mid-access: return to IDLE, no ack. A partially written word remains in RAM.
- In the accept cycle itself (still IDLE), a core write is still performed.

## Timing
- Accept in cycle T:
  - XFER occupies T+1 .. T+n, where n = 32/width.
  - Write ack at T+n+1.
  - Read: DRAIN at T+n+1, ack at T+n+2.
- width=8: write ack at T+5, read ack at T+6. width=32: write ack T+2, read ack T+3.
- Out-of-range access: ack (err=1) at T+1.
- `o_dbg_busy` is high from T+1 through the ack cycle.
- Core read latency is 1 cycle.

## Structure
- Shared package `serv_rf_dbg_pkg`: state encoding (IDLE/XFER/DRAIN/ACK), `NREGS = 32+csr_regs`, beat-count function `32/width`.
- One sub-module, `serv_rf_ram`: plain 1W1R memory with registered read. The top contains the address/data muxes, the FSM, and the shift registers.

## Test plan
- Core port, width=8: write 0xA5 to address 10, then read address 10 → `o_rdata` = 0xA5 one cycle after the read; a same-cycle read/write returns the old value.
- Halted, debug write reg 5 = 0xDEADBEEF, then debug read reg 5 → write ack at T+5; read ack at T+6 with rdata 0xDEADBEEF; core read of words {5,0..3} = EF, BE, AD, DE.
- Debug write reg 0 = 0xFFFFFFFF, then read reg 0 → RAM unchanged, rdata = 0.
- Debug read reg 36 with csr_regs=4 → ack at T+1, err=1, no RAM access.
- `i_halted`=0 with req high → no accept; raise halted → accept next cycle. Core `i_wen` pulses during XFER → RAM unchanged.
- `i_rst` asserted at T+2 of a write → busy=0 next cycle, no ack; beats 0..1 written, beats 2..3 unchanged; a new request is accepted afterwards.

Source files
------------

// File: rtl/serv_rf_dbg_pkg.sv
// serv_rf_dbg_pkg
// Shared definitions for the SERV register-file RAM with debug access:
// debug FSM state encoding, register-count and beat-count helpers.
package serv_rf_dbg_pkg;

  // Debug access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ACK   = 2'd3
  } dbg_state_e;

  localparam int NGPR = 32;

  // Total architectural registers held in the RAM (GPRs followed by CSRs)
  function automatic int nregs(input int csr_regs);
    return NGPR + csr_regs;
  endfunction

  // RAM beats needed to move one 32-bit register
  function automatic int beats(input int width);
    return 32 / width;
  endfunction

endpackage

// File: rtl/serv_rf_ram.sv
// serv_rf_ram
// Plain 1W1R memory with a registered read port. Read-during-write to the
// same address returns the old contents. Only the read register is reset;
// the storage itself keeps its contents across reset.
// Ports:
//   i_clk   clock
//   i_rst   synchronous active-high reset (read register only)
//   i_waddr write address      i_wdata write data    i_wen write enable
//   i_raddr read address       o_rdata registered read data
module serv_rf_ram #(
  parameter int width = 8,
  parameter int depth = 144
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [$clog2(depth)-1:0] i_waddr,
  input  logic [width-1:0]         i_wdata,
  input  logic                     i_wen,
  input  logic [$clog2(depth)-1:0] i_raddr,
  output logic [width-1:0]         o_rdata
);

  logic [width-1:0] mem_r [depth];

  // Storage write port
  always_ff @(posedge i_clk) begin
    if (i_wen) begin
      mem_r[i_waddr] <= i_wdata;
    end
  end

  // Registered read port; sees pre-write contents on address collision
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rdata <= {width{1'b0}};
    end else begin
      o_rdata <= mem_r[i_raddr];
    end
  end

endmodule

// File: rtl/serv_rf_ram_dbg.sv
// serv_rf_ram_dbg
// SERV register-file RAM with a word-wide debug access port. The core port
// is serviced while the debug sequencer is idle; a debug access to a whole
// 32-bit register is split into 32/width RAM beats.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_waddr/i_wdata/i_wen        core write port
//   i_raddr/o_rdata              core read port (1-cycle latency)
//   i_halted                     core halted; gates debug accept
//   i_dbg_req/we/reg/wdata       debug request (level, held until ack)
//   o_dbg_ack/err/rdata/busy     debug completion pulse, range error,
//                                read word, sequencer busy
module serv_rf_ram_dbg
  import serv_rf_dbg_pkg::*;
#(
  parameter int width    = 8,
  parameter int csr_regs = 4,
  parameter int depth    = 32 * (32 + csr_regs) / width
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [$clog2(depth)-1:0]        i_waddr,
  input  logic [width-1:0]                i_wdata,
  input  logic                            i_wen,
  input  logic [$clog2(depth)-1:0]        i_raddr,
  output logic [width-1:0]                o_rdata,
  input  logic                            i_halted,
  input  logic                            i_dbg_req,
  input  logic                            i_dbg_we,
  input  logic [$clog2(32+csr_regs)-1:0]  i_dbg_reg,
  input  logic [31:0]                     i_dbg_wdata,
  output logic                            o_dbg_ack,
  output logic                            o_dbg_err,
  output logic [31:0]                     o_dbg_rdata,
  output logic                            o_dbg_busy
);

  localparam int AW    = $clog2(depth);
  localparam int NR    = nregs(csr_regs);
  localparam int RW    = $clog2(32 + csr_regs);
  localparam int BEATS = beats(width);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  dbg_state_e        state_r, next_state_s;
  logic [BW-1:0]     beat_r;
  logic              we_r;
  logic [RW-1:0]     reg_r;
  logic [31:0]       wdata_sr_r;
  logic [31:0]       rdata_sr_r;
  logic              ack_r, err_r, busy_r;
  logic [31:0]       dbg_rdata_r;

  logic              accept_s, range_ok_s, last_beat_s;
  logic [AW-1:0]     dbg_addr_s;
  logic              ram_wen_s;
  logic [AW-1:0]     ram_waddr_s, ram_raddr_s;
  logic [width-1:0]  ram_wdata_s, ram_rdata_s;
  logic [width+31:0] cat_s;
  logic [31:0]       shifted_s;

  assign accept_s    = (state_r == ST_IDLE) & i_dbg_req & i_halted;
  assign range_ok_s  = (int'(i_dbg_reg) < NR);
  assign last_beat_s = (int'(beat_r) == BEATS - 1);
  // reg*BEATS+beat equals {reg, beat} since BEATS is a power of two
  assign dbg_addr_s  = AW'(int'(reg_r) * BEATS + int'(beat_r));
  // New RAM beat enters at the top, older beats move toward bit 0
  assign cat_s       = {ram_rdata_s, rdata_sr_r};
  assign shifted_s   = cat_s[width+31:width];

  serv_rf_ram #(.width(width), .depth(depth)) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_waddr (ram_waddr_s),
    .i_wdata (ram_wdata_s),
    .i_wen   (ram_wen_s),
    .i_raddr (ram_raddr_s),
    .o_rdata (ram_rdata_s)
  );

  assign o_rdata = ram_rdata_s;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = range_ok_s ? ST_XFER : ST_ACK;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (last_beat_s) begin
          next_state_s = we_r ? ST_ACK : ST_DRAIN;
        end else begin
          next_state_s = ST_XFER;
        end
      end
      ST_DRAIN: next_state_s = ST_ACK;
      ST_ACK:   next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // RAM port steering: core owns the RAM only while idle
  always_comb begin
    ram_wen_s   = 1'b0;
    ram_waddr_s = i_waddr;
    ram_wdata_s = i_wdata;
    ram_raddr_s = i_raddr;
    case (state_r)
      ST_IDLE: begin
        ram_wen_s = i_wen;
      end
      ST_XFER: begin
        ram_waddr_s = dbg_addr_s;
        ram_wdata_s = wdata_sr_r[width-1:0];
        ram_raddr_s = dbg_addr_s;
        // x0 is hardwired to zero, so it is never stored
        ram_wen_s   = we_r & (reg_r != {RW{1'b0}});
      end
      default: begin
        ram_raddr_s = dbg_addr_s;
        ram_wen_s   = 1'b0;
      end
    endcase
  end

  // Debug datapath: request latch, beat counter, write/read shift registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_r     <= {BW{1'b0}};
      we_r       <= 1'b0;
      reg_r      <= {RW{1'b0}};
      wdata_sr_r <= 32'd0;
      rdata_sr_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            we_r       <= i_dbg_we;
            reg_r      <= i_dbg_reg;
            wdata_sr_r <= i_dbg_wdata;
            beat_r     <= {BW{1'b0}};
          end
        end
        ST_XFER: begin
          if (!last_beat_s) begin
            beat_r <= beat_r + BW'(1);
          end
          wdata_sr_r <= wdata_sr_r >> width;
          // RAM data from the previous beat is available from beat 1 on
          if (beat_r != {BW{1'b0}}) begin
            rdata_sr_r <= shifted_s;
          end
        end
        ST_DRAIN: begin
          rdata_sr_r <= shifted_s;
        end
        default: begin
          rdata_sr_r <= rdata_sr_r;
        end
      endcase
    end
  end

  // Registered debug outputs, aligned so they are valid in the ACK cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_r       <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      dbg_rdata_r <= 32'd0;
    end else begin
      ack_r  <= (next_state_s == ST_ACK);
      busy_r <= (next_state_s != ST_IDLE);
      err_r  <= accept_s & ~range_ok_s;
      // DRAIN always leads to ACK; its capture completes the read word
      if (state_r == ST_DRAIN) begin
        dbg_rdata_r <= (reg_r == {RW{1'b0}}) ? 32'd0 : shifted_s;
      end
    end
  end

  assign o_dbg_ack   = ack_r;
  assign o_dbg_err   = err_r;
  assign o_dbg_busy  = busy_r;
  assign o_dbg_rdata = dbg_rdata_r;

endmodule

// File: tb/tb_serv_rf_ram_dbg.sv
module tb_serv_rf_ram_dbg;

  localparam int WIDTH = 8;
  localparam int CSRS  = 4;
  localparam int DEPTH = 144;
  localparam int NR    = 36;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_waddr, i_raddr;
  logic [7:0]  i_wdata;
  logic        i_wen;
  logic [7:0]  o_rdata;
  logic        i_halted, i_dbg_req, i_dbg_we;
  logic [5:0]  i_dbg_reg;
  logic [31:0] i_dbg_wdata;
  logic        o_dbg_ack, o_dbg_err, o_dbg_busy;
  logic [31:0] o_dbg_rdata;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: byte-addressed RAM image, register r lives in bytes 4r..4r+3
  logic [7:0] mdl [DEPTH];

  typedef struct {
    bit         wen;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic [7:0] raddr;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [9];

  serv_rf_ram_dbg #(.width(WIDTH), .csr_regs(CSRS)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_waddr(i_waddr), .i_wdata(i_wdata), .i_wen(i_wen),
    .i_raddr(i_raddr), .o_rdata(o_rdata),
    .i_halted(i_halted), .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we),
    .i_dbg_reg(i_dbg_reg), .i_dbg_wdata(i_dbg_wdata),
    .o_dbg_ack(o_dbg_ack), .o_dbg_err(o_dbg_err),
    .o_dbg_rdata(o_dbg_rdata), .o_dbg_busy(o_dbg_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_word(input int rg);
    if (rg == 0) return 32'd0;
    return {mdl[4*rg+3], mdl[4*rg+2], mdl[4*rg+1], mdl[4*rg]};
  endfunction

  task automatic core_op(input bit wen, input int wa, input logic [7:0] wd, input int ra);
    logic [7:0] exp;
    exp = mdl[ra];
    i_wen = wen; i_waddr = 8'(wa); i_wdata = wd; i_raddr = 8'(ra);
    step();
    chk("core_rdata", {24'd0, o_rdata}, {24'd0, exp});
    if (wen) mdl[wa] = wd;
    i_wen = 1'b0;
  endtask

  // One debug access with latency, error and data checks against the model
  task automatic dbg_op(input bit we, input int rg, input logic [31:0] wd, input bit noise);
    int k;
    int exp_k;
    bit oor;
    logic [31:0] exp_rd;
    oor    = (rg >= NR);
    exp_rd = oor ? 32'd0 : mdl_word(rg);
    i_dbg_req = 1'b1; i_dbg_we = we; i_dbg_reg = 6'(rg); i_dbg_wdata = wd;
    step();
    chk("busy_after_accept", {31'd0, o_dbg_busy}, 32'd1);
    if (noise) begin
      i_wen = 1'b1; i_waddr = 8'd100; i_wdata = 8'h77;
    end
    k = 1;
    while (o_dbg_ack !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    i_dbg_req = 1'b0;
    i_wen = 1'b0;
    exp_k = oor ? 1 : (we ? 5 : 6);
    chk("ack_latency", k, exp_k);
    chk("ack_err", {31'd0, o_dbg_err}, {31'd0, oor});
    chk("busy_in_ack", {31'd0, o_dbg_busy}, 32'd1);
    if (!we && !oor) chk("dbg_rdata", o_dbg_rdata, exp_rd);
    if (we && !oor && rg != 0) begin
      for (int b = 0; b < 4; b++) mdl[4*rg+b] = wd[8*b +: 8];
    end
    step();
    chk("idle_after_ack", {30'd0, o_dbg_busy, o_dbg_ack}, 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'd10,  8'hA5, 8'd10,  8'h0A};
    tbl[1] = '{1'b0, 8'd0,   8'h00, 8'd10,  8'hA5};
    tbl[2] = '{1'b1, 8'd20,  8'h5A, 8'd11,  8'h0B};
    tbl[3] = '{1'b0, 8'd0,   8'h00, 8'd20,  8'h5A};
    tbl[4] = '{1'b1, 8'd143, 8'hFF, 8'd143, 8'h8F};
    tbl[5] = '{1'b0, 8'd0,   8'h00, 8'd143, 8'hFF};
    tbl[6] = '{1'b0, 8'd0,   8'h00, 8'd0,   8'h00};
    tbl[7] = '{1'b1, 8'd0,   8'h11, 8'd1,   8'h01};
    tbl[8] = '{1'b0, 8'd0,   8'h00, 8'd0,   8'h11};

    i_rst = 1'b1; i_wen = 1'b0; i_waddr = 8'd0; i_wdata = 8'd0; i_raddr = 8'd0;
    i_halted = 1'b1; i_dbg_req = 1'b0; i_dbg_we = 1'b0; i_dbg_reg = 6'd0;
    i_dbg_wdata = 32'd0;
    step();
    step();
    chk("rst_rdata", {24'd0, o_rdata}, 32'd0);
    chk("rst_dbg_rdata", o_dbg_rdata, 32'd0);
    chk("rst_flags", {29'd0, o_dbg_ack, o_dbg_err, o_dbg_busy}, 32'd0);
    i_rst = 1'b0;

    // Fill RAM with its own address so later expectations are known constants
    for (int a = 0; a < DEPTH; a++) begin
      i_wen = 1'b1; i_waddr = 8'(a); i_wdata = 8'(a);
      step();
      mdl[a] = 8'(a);
    end
    i_wen = 1'b0;

    // Core-port vectors, including read-during-write and the top address
    for (int i = 0; i < 9; i++) begin
      i_wen = tbl[i].wen; i_waddr = tbl[i].waddr; i_wdata = tbl[i].wdata;
      i_raddr = tbl[i].raddr;
      step();
      chk($sformatf("tbl%0d", i), {24'd0, o_rdata}, {24'd0, tbl[i].exp});
      if (tbl[i].wen) mdl[tbl[i].waddr] = tbl[i].wdata;
    end
    i_wen = 1'b0;

    // Debug write/read of reg 5, then core view of its bytes
    dbg_op(1'b1, 5, 32'hDEADBEEF, 1'b0);
    dbg_op(1'b0, 5, 32'h0, 1'b0);
    chk("reg5_word", mdl_word(5), 32'hDEADBEEF);
    core_op(1'b0, 0, 8'h00, 20);
    chk("reg5_b0", {24'd0, o_rdata}, 32'h000000EF);
    core_op(1'b0, 0, 8'h00, 21);
    chk("reg5_b1", {24'd0, o_rdata}, 32'h000000BE);
    core_op(1'b0, 0, 8'h00, 22);
    chk("reg5_b2", {24'd0, o_rdata}, 32'h000000AD);
    core_op(1'b0, 0, 8'h00, 23);
    chk("reg5_b3", {24'd0, o_rdata}, 32'h000000DE);

    // x0: writes suppressed, reads forced to zero
    dbg_op(1'b1, 0, 32'hFFFFFFFF, 1'b0);
    dbg_op(1'b0, 0, 32'h0, 1'b0);
    for (int a = 0; a < 4; a++) core_op(1'b0, 0, 8'h00, a);

    // Out-of-range register
    dbg_op(1'b0, 36, 32'h0, 1'b0);
    dbg_op(1'b1, 40, 32'h12345678, 1'b0);

    // Not halted: no accept; core write noise during XFER is dropped
    i_halted = 1'b0;
    i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_reg = 6'd9; i_dbg_wdata = 32'h0BADF00D;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("no_accept_unhalted", {31'd0, o_dbg_busy}, 32'd0);
    end
    i_halted = 1'b1;
    dbg_op(1'b1, 9, 32'h0BADF00D, 1'b1);
    core_op(1'b0, 0, 8'h00, 100);
    dbg_op(1'b0, 9, 32'h0, 1'b0);

    // Reset in the middle of a debug write to reg 7
    i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_reg = 6'd7; i_dbg_wdata = 32'hCAFEF00D;
    step();
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0; i_dbg_req = 1'b0;
    chk("rst_mid_busy", {30'd0, o_dbg_busy, o_dbg_ack}, 32'd0);
    chk("rst_mid_rdata", {24'd0, o_rdata}, 32'd0);
    mdl[28] = 8'h0D;
    mdl[29] = 8'hF0;
    step();
    chk("rst_mid_no_ack", {31'd0, o_dbg_ack}, 32'd0);
    for (int a = 28; a < 32; a++) core_op(1'b0, 0, 8'h00, a);
    dbg_op(1'b0, 7, 32'h0, 1'b0);

    // Randomized mix of core and debug traffic against the model
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        core_op(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH-1)),
                8'($urandom), int'($urandom_range(0, DEPTH-1)));
      end else begin
        dbg_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 40)),
               32'($urandom), 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
